// File: rtl/ow_pkg.sv
// ow_pkg: 1-Wire PHY op codes, slot timing in microseconds
// and the master FSM state encoding.
package ow_pkg;

   typedef enum logic [2:0] {
      OW_OP_RESET      = 3'd0,
      OW_OP_WRITE_BIT  = 3'd1,
      OW_OP_READ_BIT   = 3'd2,
      OW_OP_WRITE_BYTE = 3'd3,
      OW_OP_READ_BYTE  = 3'd4
   } ow_op_e;

   localparam int T_RSTL    = 480;
   localparam int T_PDS     = 70;
   localparam int T_RST_TOT = 960;
   localparam int T_LOW1    = 6;
   localparam int T_LOW0    = 60;
   localparam int T_RDS     = 15;
   localparam int T_SLOT    = 70;
   localparam int T_REC     = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RST_LOW,
      ST_RST_REL,
      ST_SLOT_LOW,
      ST_SLOT_REL,
      ST_RECOVERY
   } ow_state_e;

   function automatic logic op_is_slot(logic [2:0] op);
      return op inside {OW_OP_WRITE_BIT, OW_OP_READ_BIT,
                        OW_OP_WRITE_BYTE, OW_OP_READ_BYTE};
   endfunction

   function automatic logic op_is_read(logic [2:0] op);
      return op inside {OW_OP_READ_BIT, OW_OP_READ_BYTE};
   endfunction

   function automatic logic op_is_byte(logic [2:0] op);
      return op inside {OW_OP_WRITE_BYTE, OW_OP_READ_BYTE};
   endfunction

endpackage

// File: rtl/ow_master_phy_sync2.sv
// ow_sync2: two-flop synchroniser for the raw bus level.
// Resets to 1 so an idle pulled-up bus is seen after reset.
module ow_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // shift the asynchronous level through two flops
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ow_master_phy.sv
// ow_master_phy: 1-Wire master PHY producing timed reset,
// write and read slots on an open-drain bus.
module ow_master_phy #(
   parameter int CLKS_PER_US = 100,
   parameter int CNT_W       = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_presence,
   output logic       rsp_short,
   output logic       bus_oe,
   input  logic       bus_in
);
   import ow_pkg::*;

   typedef logic [CNT_W-1:0] cnt_t;

   // counter values at which each phase ends or samples
   localparam cnt_t C_RSTL = cnt_t'(T_RSTL * CLKS_PER_US - 1);
   localparam cnt_t C_PDS  = cnt_t'((T_RSTL + T_PDS) * CLKS_PER_US);
   localparam cnt_t C_RTOT = cnt_t'(T_RST_TOT * CLKS_PER_US - 1);
   localparam cnt_t C_LOW1 = cnt_t'(T_LOW1 * CLKS_PER_US - 1);
   localparam cnt_t C_LOW0 = cnt_t'(T_LOW0 * CLKS_PER_US - 1);
   localparam cnt_t C_RDS  = cnt_t'(T_RDS * CLKS_PER_US);
   localparam cnt_t C_SLOT = cnt_t'(T_SLOT * CLKS_PER_US - 1);
   localparam cnt_t C_BIT  = cnt_t'((T_SLOT + T_REC) * CLKS_PER_US - 1);

   ow_state_e  state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic [2:0] op_q, op_d;
   logic       pres_q, pres_d;
   logic       oe_d, vld_d, prs_d, sht_d;
   logic [7:0] dat_d;
   logic       bus_s, is_rd, bit_one;
   logic [2:0] last;
   cnt_t       low_end;

   ow_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus_in),
      .q   (bus_s)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign is_rd     = op_is_read(op_q);
   assign bit_one   = is_rd | sh_q[0];
   assign last      = op_is_byte(op_q) ? 3'd7 : 3'd0;
   assign low_end   = bit_one ? C_LOW1 : C_LOW0;

   // next-state, timing and response computation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + cnt_t'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      op_d    = op_q;
      pres_d  = pres_q;
      oe_d    = bus_oe;
      vld_d   = 1'b0;
      dat_d   = rsp_data;
      prs_d   = rsp_presence;
      sht_d   = rsp_short;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            oe_d  = 1'b0;
            if (req_valid) begin
               op_d   = req_op;
               sh_d   = req_data;
               bit_d  = 3'd0;
               pres_d = 1'b0;
               unique case (1'b1)
                  (req_op == OW_OP_RESET): begin
                     state_d = ST_RST_LOW;
                     oe_d    = 1'b1;
                  end
                  op_is_slot(req_op): begin
                     state_d = ST_SLOT_LOW;
                     oe_d    = 1'b1;
                  end
                  default: begin
                     vld_d = 1'b1;
                     dat_d = 8'h00;
                     prs_d = 1'b0;
                     sht_d = 1'b0;
                  end
               endcase
            end
         end
         ST_RST_LOW: begin
            if (cnt_q == C_RSTL) begin
               oe_d    = 1'b0;
               state_d = ST_RST_REL;
            end
         end
         ST_RST_REL: begin
            if (cnt_q == C_PDS) pres_d = ~bus_s;
            if (cnt_q == C_RTOT) begin
               state_d = ST_IDLE;
               vld_d   = 1'b1;
               dat_d   = 8'h00;
               prs_d   = pres_q;
               sht_d   = ~bus_s;
            end
         end
         ST_SLOT_LOW: begin
            if (cnt_q == low_end) begin
               oe_d    = 1'b0;
               state_d = ST_SLOT_REL;
            end
         end
         ST_SLOT_REL: begin
            if (is_rd && cnt_q == C_RDS)
               sh_d = {bus_s, sh_q[7:1]};
            if (cnt_q == C_SLOT) state_d = ST_RECOVERY;
         end
         ST_RECOVERY: begin
            if (cnt_q == C_BIT) begin
               cnt_d = '0;
               if (bit_q == last) begin
                  state_d = ST_IDLE;
                  vld_d   = 1'b1;
                  prs_d   = 1'b0;
                  sht_d   = 1'b0;
                  if (op_q == OW_OP_READ_BYTE)
                     dat_d = sh_q;
                  else if (op_q == OW_OP_READ_BIT)
                     dat_d = {7'd0, sh_q[7]};
                  else
                     dat_d = 8'h00;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  state_d = ST_SLOT_LOW;
                  oe_d    = 1'b1;
                  if (!is_rd) sh_d = {1'b0, sh_q[7:1]};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         sh_q         <= '0;
         op_q         <= '0;
         pres_q       <= 1'b0;
         bus_oe       <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_presence <= 1'b0;
         rsp_short    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         sh_q         <= sh_d;
         op_q         <= op_d;
         pres_q       <= pres_d;
         bus_oe       <= oe_d;
         rsp_valid    <= vld_d;
         rsp_data     <= dat_d;
         rsp_presence <= prs_d;
         rsp_short    <= sht_d;
      end
   end

endmodule

// File: tb/tb_ow_master_phy.sv
// tb_ow_master_phy: directed bench for the 1-Wire master PHY
// with a small slave model on the bus.
module tb_ow_master_phy;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_op = 3'd0;
   logic [7:0] req_data = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_presence;
   logic       rsp_short;
   logic       bus_oe;
   logic       bus_in;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int t_acc = 0;
   int lat;
   int wbase;
   int pulses;

   logic       pres_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_byte = 8'h00;
   logic       force_low = 1'b0;
   int         rd_base = 0;
   int         nfall = 0;
   int         since_fall = 1000000;
   int         since_rise = 1000000;
   logic       prev_oe = 1'b0;
   int         run = 0;
   int         widths[$];
   logic [2:0] rd_idx;
   logic       slave_low;

   ow_master_phy #(
      .CLKS_PER_US (10),
      .CNT_W       (17)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_data     (req_data),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_presence (rsp_presence),
      .rsp_short    (rsp_short),
      .bus_oe       (bus_oe),
      .bus_in       (bus_in)
   );

   always #5 clk = ~clk;

   assign rd_idx = 3'(nfall - rd_base - 1);
   assign slave_low =
      (pres_en && since_rise >= 300 && since_rise < 1500) ||
      (rd_en && !rd_byte[rd_idx] && since_fall < 300);
   assign bus_in = ~(bus_oe | slave_low | force_low);

   // cycle count, slave timing and low-pulse width log
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      prev_oe <= bus_oe;
      if (bus_oe && !prev_oe) begin
         since_fall <= 0;
         nfall      <= nfall + 1;
      end else begin
         since_fall <= since_fall + 1;
      end
      if (!bus_oe && prev_oe) since_rise <= 0;
      else since_rise <= since_rise + 1;
      if (bus_oe) run <= run + 1;
      else if (run != 0) begin
         widths.push_back(run);
         run <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      @(posedge clk);
      #1;
      t_acc     = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int budget, output int l);
      l = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            l = cyc - t_acc;
            break;
         end
      end
   endtask

   task automatic chk_width(input string tag, input int idx,
                            input int exp);
      int w;
      w = (idx < widths.size()) ? widths[idx] : -1;
      chk(tag, 32'(w), 32'(exp));
   endtask

   initial begin
      int exp_w[8];
      exp_w = '{60, 600, 60, 600, 600, 60, 600, 60};

      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_oe", 32'(bus_oe), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_pres", 32'(rsp_presence), 32'd0);
      chk("rst_short", 32'(rsp_short), 32'd0);

      pres_en = 1'b1;
      wbase = widths.size();
      issue(3'd0, 8'h00);
      chk("reset_ready_drop", 32'(req_ready), 32'd0);
      chk("reset_oe_rise", 32'(bus_oe), 32'd1);
      wait_rsp(12000, lat);
      chk("reset_lat", 32'(lat), 32'd9600);
      chk("reset_pres", 32'(rsp_presence), 32'd1);
      chk("reset_short", 32'(rsp_short), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk_width("reset_low", wbase, 4800);
      @(posedge clk);
      #1;
      chk("reset_pulse1", 32'(rsp_valid), 32'd0);
      chk("reset_hold", 32'(rsp_presence), 32'd1);
      pres_en = 1'b0;

      issue(3'd0, 8'h00);
      wait_rsp(12000, lat);
      chk("noslave_lat", 32'(lat), 32'd9600);
      chk("noslave_pres", 32'(rsp_presence), 32'd0);
      chk("noslave_short", 32'(rsp_short), 32'd0);

      force_low = 1'b1;
      issue(3'd0, 8'h00);
      wait_rsp(12000, lat);
      chk("short_pres", 32'(rsp_presence), 32'd1);
      chk("short_short", 32'(rsp_short), 32'd1);
      force_low = 1'b0;
      repeat (3) @(posedge clk);

      wbase = widths.size();
      issue(3'd3, 8'hA5);
      wait_rsp(8000, lat);
      chk("wbyte_lat", 32'(lat), 32'd6400);
      chk("wbyte_data", 32'(rsp_data), 32'd0);
      chk("wbyte_pres", 32'(rsp_presence), 32'd0);
      for (int i = 0; i < 8; i++)
         chk_width($sformatf("wbyte_w%0d", i), wbase + i, exp_w[i]);

      rd_en   = 1'b1;
      rd_byte = 8'h3C;
      rd_base = nfall;
      wbase   = widths.size();
      issue(3'd4, 8'h00);
      wait_rsp(8000, lat);
      chk("rbyte_lat", 32'(lat), 32'd6400);
      chk("rbyte_data", 32'(rsp_data), 32'h3C);
      for (int i = 0; i < 8; i++)
         chk_width($sformatf("rbyte_w%0d", i), wbase + i, 60);

      rd_byte = 8'h00;
      rd_base = nfall;
      issue(3'd2, 8'h00);
      wait_rsp(2000, lat);
      chk("rbit0_lat", 32'(lat), 32'd800);
      chk("rbit0_data", 32'(rsp_data), 32'h00);
      rd_en = 1'b0;

      issue(3'd2, 8'h00);
      wait_rsp(2000, lat);
      chk("rbit1_data", 32'(rsp_data), 32'h01);

      issue(3'd1, 8'h00);
      repeat (199) @(posedge clk);
      #1;
      chk("abort_oe_before", 32'(bus_oe), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_oe", 32'(bus_oe), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid || bus_oe) pulses++;
      end
      chk("abort_quiet", 32'(pulses), 32'd0);

      issue(3'd7, 8'hFF);
      chk("illegal_valid", 32'(rsp_valid), 32'd1);
      chk("illegal_oe", 32'(bus_oe), 32'd0);
      chk("illegal_data", 32'(rsp_data), 32'd0);
      @(posedge clk);
      #1;
      chk("illegal_pulse1", 32'(rsp_valid), 32'd0);
      chk("illegal_oe2", 32'(bus_oe), 32'd0);

      wbase = widths.size();
      issue(3'd1, 8'h01);
      req_valid = 1'b1;
      req_op    = 3'd0;
      repeat (100) @(posedge clk);
      #1;
      chk("busy_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      wait_rsp(2000, lat);
      chk("busy_lat", 32'(lat), 32'd800);
      chk_width("busy_w1", wbase, 60);
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (bus_oe || rsp_valid) pulses++;
      end
      chk("busy_no_second", 32'(pulses), 32'd0);
      chk("busy_one_slot", 32'(widths.size() - wbase), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
